// File: rtl/sprite_compositor.sv
// Sprite layer: Avalon staging/active sprite registers, priority cover test, ROM address
// generation, latency-matched transparency output and sticky overlap flags.
module sprite_compositor #(
    parameter int N_SPRITES   = 4,
    parameter int SPRITE_LOG2 = 4,
    parameter int ROM_LATENCY = 2,
    parameter int ADDR_W      = 5
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       chipselect_i,
    input  logic                       write_i,
    input  logic                       read_i,
    input  logic [ADDR_W-1:0]          address_i,
    input  logic [15:0]                writedata_i,
    output logic [15:0]                readdata_o,
    input  logic [10:0]                hcount_i,
    input  logic [9:0]                 vcount_i,
    output logic [6+2*SPRITE_LOG2-1:0] rom_addr_o,
    input  logic [7:0]                 rom_q_i,
    output logic                       pix_hit_o,
    output logic [7:0]                 pix_color_o
);

    localparam int S    = SPRITE_LOG2;
    localparam int N    = N_SPRITES;
    localparam int RA_W = 6 + 2*S;
    localparam logic [10:0]       EDGE_X    = 11'((1 << S) - 1);
    localparam logic [9:0]        EDGE_Y    = 10'((1 << S) - 1);
    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(2*N);
    localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(2*N + 1);

    typedef struct packed {
        logic       en;
        logic       hf;
        logic       vf;
        logic [9:0] x;
        logic [5:0] frame;
        logic [8:0] y;
    } spr_t;

    spr_t stg_q [N];
    spr_t stg_d [N];
    spr_t act_q [N];
    spr_t act_d [N];

    logic             ctrl_q, ctrl_d;
    logic [N-1:0]     status_q, status_d;
    logic [N-1:0]     clr_w;
    logic             fs_q;
    logic [15:0]      readdata_q, readdata_d;
    logic [RA_W-1:0]  rom_addr_q, rom_addr_d;
    logic [ROM_LATENCY:0] cov_sr_q;
    logic             pix_hit_q, pix_hit_d;
    logic [7:0]       pix_color_q;

    logic             frame_start;
    logic [10:0]      px_w;
    logic [9:0]       py_w;
    logic [N-1:0]     cov_vec;
    logic [RA_W-1:0]  spr_addr [N];
    logic             any_cov;
    logic             multi_cov;
    logic             in_active;

    assign frame_start = (hcount_i == 11'd0) && (vcount_i == 10'd480);
    assign px_w        = {1'b0, hcount_i[10:1]};
    assign py_w        = {1'b0, vcount_i[8:0]};

    always_comb begin
        stg_d  = stg_q;
        ctrl_d = ctrl_q;
        clr_w  = '0;
        if (chipselect_i && write_i) begin
            for (int i = 0; i < N; i++) begin
                if (address_i == ADDR_W'(2*i)) begin
                    stg_d[i].en = writedata_i[15];
                    stg_d[i].hf = writedata_i[14];
                    stg_d[i].vf = writedata_i[13];
                    stg_d[i].x  = writedata_i[9:0];
                end
                if (address_i == ADDR_W'(2*i + 1)) begin
                    stg_d[i].frame = writedata_i[15:10];
                    stg_d[i].y     = writedata_i[8:0];
                end
            end
            if (address_i == CTRL_ADDR) ctrl_d = writedata_i[0];
            if (address_i == STAT_ADDR) clr_w  = writedata_i[N-1:0];
        end
    end

    // Shadow copy uses the pre-write staging value, so a write landing on the copy cycle waits a frame.
    always_comb begin
        if (!ctrl_q)   act_d = stg_d;
        else if (fs_q) act_d = stg_q;
        else           act_d = act_q;
    end

    always_comb begin
        readdata_d = '0;
        for (int i = 0; i < N; i++) begin
            if (address_i == ADDR_W'(2*i))
                readdata_d = {stg_q[i].en, stg_q[i].hf, stg_q[i].vf, 3'b000, stg_q[i].x};
            if (address_i == ADDR_W'(2*i + 1))
                readdata_d = {stg_q[i].frame, 1'b0, stg_q[i].y};
        end
        if (address_i == CTRL_ADDR) readdata_d = {15'd0, ctrl_q};
        if (address_i == STAT_ADDR) readdata_d = 16'(status_q);
    end

    for (genvar g = 0; g < N; g++) begin : g_cover
        logic [10:0]  x_lo, x_hi;
        logic [9:0]   y_lo, y_hi;
        logic [S-1:0] col, row;
        assign x_lo = {1'b0, act_q[g].x};
        assign x_hi = x_lo + EDGE_X;
        assign y_lo = {1'b0, act_q[g].y};
        assign y_hi = y_lo + EDGE_Y;
        assign cov_vec[g] = act_q[g].en && (px_w >= x_lo) && (px_w <= x_hi)
                            && (py_w >= y_lo) && (py_w <= y_hi);
        assign col = px_w[S-1:0] - act_q[g].x[S-1:0];
        assign row = py_w[S-1:0] - act_q[g].y[S-1:0];
        assign spr_addr[g] = {act_q[g].frame, (act_q[g].vf ? ~row : row),
                              (act_q[g].hf ? ~col : col)};
    end

    always_comb begin
        rom_addr_d = '0;
        any_cov    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cov_vec[i]) begin
                rom_addr_d = spr_addr[i];
                any_cov    = 1'b1;
            end
        end
    end

    assign multi_cov = |(cov_vec & (cov_vec - 1'b1));
    assign in_active = (vcount_i < 10'd480) && (hcount_i < 11'd1280);
    assign status_d  = (status_q & ~clr_w) | ((multi_cov && in_active) ? cov_vec : '0);
    assign pix_hit_d = cov_sr_q[ROM_LATENCY] && (rom_q_i != 8'd0);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < N; i++) begin
                stg_q[i] <= '0;
                act_q[i] <= '0;
            end
            ctrl_q      <= 1'b0;
            status_q    <= '0;
            fs_q        <= 1'b0;
            readdata_q  <= '0;
            rom_addr_q  <= '0;
            cov_sr_q    <= '0;
            pix_hit_q   <= 1'b0;
            pix_color_q <= '0;
        end else begin
            stg_q       <= stg_d;
            act_q       <= act_d;
            ctrl_q      <= ctrl_d;
            status_q    <= status_d;
            fs_q        <= frame_start;
            if (chipselect_i && read_i) readdata_q <= readdata_d;
            rom_addr_q  <= rom_addr_d;
            cov_sr_q    <= {cov_sr_q[ROM_LATENCY-1:0], any_cov};
            pix_hit_q   <= pix_hit_d;
            pix_color_q <= pix_hit_d ? rom_q_i : 8'd0;
        end
    end

    assign readdata_o  = readdata_q;
    assign rom_addr_o  = rom_addr_q;
    assign pix_hit_o   = pix_hit_q;
    assign pix_color_o = pix_color_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: three builds (ROM latency 2, 1, 4) share stimulus; a
// scoreboard queue holds expected rom_addr / pixel / readdata values with their due cycle.
module tb_sprite_compositor;

    localparam int N    = 4;
    localparam int S    = 4;
    localparam int AW   = 5;
    localparam int RA_W = 6 + 2*S;
    localparam int NDUT = 3;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    endfunction

    // ROM image: address 0 and any {row 15, col 14} pixel are transparent.
    function automatic logic [7:0] rom_fn(input logic [RA_W-1:0] a);
        if (a == '0) return 8'd0;
        if (a[7:0] == 8'hFE) return 8'd0;
        return 8'h07;
    endfunction

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic            reset_n = 1'b0;
    logic            cs = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [AW-1:0]   addr = '0;
    logic [15:0]     wdata = '0;
    logic [10:0]     hcount = 11'd1500;
    logic [9:0]      vcount = 10'd500;

    logic [15:0]     rdata     [NDUT];
    logic [RA_W-1:0] rom_addr  [NDUT];
    logic [7:0]      rom_q     [NDUT];
    logic            pix_hit   [NDUT];
    logic [7:0]      pix_color [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int LAT = lat_of(g);
        logic [7:0] pipe [LAT];
        sprite_compositor #(
            .N_SPRITES(N), .SPRITE_LOG2(S), .ROM_LATENCY(LAT), .ADDR_W(AW)
        ) u_dut (
            .clk_i(clk), .reset_n_i(reset_n), .chipselect_i(cs), .write_i(wr),
            .read_i(rd), .address_i(addr), .writedata_i(wdata), .readdata_o(rdata[g]),
            .hcount_i(hcount), .vcount_i(vcount), .rom_addr_o(rom_addr[g]),
            .rom_q_i(rom_q[g]), .pix_hit_o(pix_hit[g]), .pix_color_o(pix_color[g])
        );
        always @(posedge clk) begin
            pipe[0] <= rom_fn(rom_addr[g]);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign rom_q[g] = pipe[LAT-1];
    end

    typedef struct {
        int          due;
        int          kind;
        int          dut;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                mon_e = sb[i];
                sb.delete(i);
                case (mon_e.kind)
                    0: chk($sformatf("rom_addr[%0d]", mon_e.dut), 32'(rom_addr[mon_e.dut]), 32'(mon_e.exp));
                    1: chk($sformatf("pix[%0d]", mon_e.dut),
                           {23'd0, pix_hit[mon_e.dut], pix_color[mon_e.dut]}, 32'(mon_e.exp));
                    default: chk("readdata", 32'(rdata[0]), 32'(mon_e.exp));
                endcase
            end
        end
    end

    task automatic drive(input logic [10:0] h, input logic [9:0] v, input logic c,
                         input logic w, input logic r, input logic [AW-1:0] a,
                         input logic [15:0] d);
        @(negedge clk);
        hcount = h; vcount = v; cs = c; wr = w; rd = r; addr = a; wdata = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(11'd1500, 10'd500, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic av_write(input logic [AW-1:0] a, input logic [15:0] d);
        drive(11'd1500, 10'd500, 1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic av_read(input logic [AW-1:0] a, input logic [15:0] exp);
        drive(11'd1500, 10'd500, 1'b1, 1'b0, 1'b1, a, '0);
        sb.push_back('{cyc + 1, 2, 0, exp});
    endtask

    task automatic scan_x(input logic [10:0] h, input logic [9:0] v, input logic cov,
                          input logic [RA_W-1:0] ea, input logic w,
                          input logic [AW-1:0] a, input logic [15:0] d);
        logic [7:0] c;
        drive(h, v, w, w, 1'b0, a, d);
        c = cov ? rom_fn(ea) : 8'd0;
        for (int k = 0; k < NDUT; k++) begin
            sb.push_back('{cyc + 1, 0, k, 16'(cov ? ea : '0)});
            sb.push_back('{cyc + 2 + lat_of(k), 1, k, {7'd0, (c != 8'd0), c}});
        end
    endtask

    task automatic scan(input logic [10:0] h, input logic [9:0] v, input logic cov,
                        input logic [RA_W-1:0] ea);
        scan_x(h, v, cov, ea, 1'b0, '0, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk("rst_pix_hit", 32'(pix_hit[k]), 32'd0);
            chk("rst_pix_color", 32'(pix_color[k]), 32'd0);
            chk("rst_rom_addr", 32'(rom_addr[k]), 32'd0);
            chk("rst_readdata", 32'(rdata[k]), 32'd0);
        end
        reset_n = 1'b1;
        for (int a = 0; a < 2*N + 2; a++) av_read(AW'(a), 16'h0000);
        av_read(5'd10, 16'h0000);
        av_read(5'd31, 16'h0000);
        scan(11'd400, 10'd200, 1'b0, '0);
        scan(11'd0, 10'd0, 1'b0, '0);
        idle(8);

        // basic placement, boundaries, readback
        av_write(5'd0, 16'h8064);
        av_write(5'd1, 16'h0832);
        av_read(5'd0, 16'h8064);
        av_read(5'd1, 16'h0832);
        av_write(5'd3, 16'hFFFF);
        av_read(5'd3, 16'hFDFF);
        av_write(5'd3, 16'h0000);
        scan(11'd200, 10'd50, 1'b1, 14'h200);
        scan(11'd232, 10'd50, 1'b0, '0);
        scan(11'd230, 10'd50, 1'b1, 14'h20F);
        scan(11'd198, 10'd50, 1'b0, '0);
        scan(11'd200, 10'd65, 1'b1, 14'h2F0);
        scan(11'd200, 10'd66, 1'b0, '0);
        scan(11'd201, 10'd50, 1'b1, 14'h200);
        idle(8);

        // flips and transparency
        av_write(5'd0, 16'hE064);
        scan(11'd202, 10'd50, 1'b1, 14'h2FE);
        scan(11'd200, 10'd50, 1'b1, 14'h2FF);
        scan(11'd230, 10'd65, 1'b1, 14'h200);
        idle(8);

        // priority and collision
        av_write(5'd0, 16'h80C8);
        av_write(5'd1, 16'h08C8);
        av_write(5'd4, 16'h80C8);
        av_write(5'd5, 16'h14C8);
        av_read(5'd9, 16'h0000);
        scan(11'd400, 10'd200, 1'b1, 14'h200);
        idle(2);
        av_read(5'd9, 16'h0005);
        av_write(5'd9, 16'h0001);
        av_read(5'd9, 16'h0004);
        av_write(5'd9, 16'h0004);
        av_read(5'd9, 16'h0000);
        scan_x(11'd400, 10'd200, 1'b1, 14'h200, 1'b1, 5'd9, 16'h0005);
        av_read(5'd9, 16'h0005);
        av_write(5'd9, 16'h0005);
        av_read(5'd9, 16'h0000);
        scan(11'd400, 10'd712, 1'b1, 14'h200);
        idle(1);
        av_read(5'd9, 16'h0000);
        av_write(5'd4, 16'h83FC);
        scan(11'd2046, 10'd200, 1'b1, 14'h503);
        scan(11'd6, 10'd200, 1'b0, '0);
        av_write(5'd4, 16'h0000);
        idle(8);

        // shadow registers
        av_write(5'd2, 16'h800A);
        av_write(5'd3, 16'h0C64);
        av_write(5'd8, 16'h0001);
        av_read(5'd8, 16'h0001);
        scan(11'd20, 10'd100, 1'b1, 14'h300);
        av_write(5'd2, 16'h812C);
        av_read(5'd2, 16'h812C);
        scan(11'd20, 10'd100, 1'b1, 14'h300);
        scan(11'd600, 10'd100, 1'b0, '0);
        scan(11'd0, 10'd480, 1'b0, '0);
        scan_x(11'd2, 10'd480, 1'b0, '0, 1'b1, 5'd2, 16'h8190);
        scan(11'd600, 10'd100, 1'b1, 14'h300);
        scan(11'd20, 10'd100, 1'b0, '0);
        scan(11'd800, 10'd100, 1'b0, '0);
        scan(11'd0, 10'd480, 1'b0, '0);
        scan(11'd2, 10'd480, 1'b0, '0);
        scan(11'd800, 10'd100, 1'b1, 14'h300);
        scan(11'd600, 10'd100, 1'b0, '0);
        idle(8);

        // reset in the middle of a covered run
        repeat (3) scan(11'd400, 10'd200, 1'b1, 14'h200);
        repeat (6) drive(11'd400, 10'd200, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("pre_reset_hit", 32'(pix_hit[0]), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk("midrst_pix_hit", 32'(pix_hit[k]), 32'd0);
            chk("midrst_pix_color", 32'(pix_color[k]), 32'd0);
            chk("midrst_rom_addr", 32'(rom_addr[k]), 32'd0);
        end
        reset_n = 1'b1;
        scan(11'd400, 10'd200, 1'b0, '0);
        av_read(5'd0, 16'h0000);
        av_read(5'd8, 16'h0000);
        idle(8);

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised sprite layer for the VGA display path. Holds position, frame and flip state for N_SPRITES sprites in Avalon-writable registers and buffers them in shadow registers latched at frame start, so software updates never tear mid-frame. For each scan position it picks the highest-priority covering sprite and generates the sprite ROM address. It then returns a pipeline-aligned colour index with transparency, plus sticky bounding-box collision flags. It sits between the vga counter (hcount/vcount) and the global colour lookup, replacing hard-coded two-player logic.

## Interface

- N_SPRITES, 4: number of sprites; 1..8.
- SPRITE_LOG2, 4: sprite edge is 2^SPRITE_LOG2 pixels (default 16x16).
- ROM_LATENCY, 2: cycles from rom_addr to rom_q; 1..4.
- ADDR_W, 5: Avalon word-address width; must satisfy 2^ADDR_W >= 2*N_SPRITES+2.

Ports:

- clk  in  1  system clock (50 MHz); one clock domain.
- reset_n  in  1  synchronous, active-low reset.
- chipselect  in  1  Avalon slave select.
- write  in  1  write strobe.
- read  in  1  read strobe.
- address  in  ADDR_W  word address.
- writedata  in  16  write data.
- readdata  out  16  read data, valid one cycle after read.
- hcount  in  11  horizontal count; pixel x = hcount[10:1].
- vcount  in  10  vertical count; pixel y = vcount[8:0].
- rom_addr  out  6+2*SPRITE_LOG2  sprite ROM address, registered.
- rom_q  in  8  ROM colour index, ROM_LATENCY cycles after rom_addr.
- pix_hit  out  1  opaque sprite pixel present.
- pix_color  out  8  sprite colour index; 0 when pix_hit=0.

## Operation

Register map (staging registers; reads return staging values):
- 2i: [15] enable, [14] hflip, [13] vflip, [9:0] x.
- 2i+1: [15:10] frame, [8:0] y.
- 2N: control; [0] shadow_mode.
- 2N+1: status; [N-1:0] collision, sticky.
  - Write 1 to clear a bit; write 0 leaves it.
  - Read clears nothing.
- Unmapped addresses: writes ignored, reads return 0.

Shadow registers:
- frame_start = (hcount==0 && vcount==480).
- shadow_mode=1: all active sprite registers copy from staging on the cycle after frame_start.
- shadow_mode=0: active registers track staging; a write is visible to the pipeline the cycle after it is written.

Cover test (active registers):
- Sprite i covers the pixel when enable=1, x <= px <= x+2^S-1 and y <= py <= y+2^S-1.
- Compare widths are 11/10 bits, so no wrap at the right or bottom edge.
- Priority: lowest index wins.
- col = px-x and row = py-y, each S bits.
- hflip inverts col; vflip inverts row.
- rom_addr = {frame, row, col}.

Collision:
- If two or more sprites cover the same pixel with vcount<480 and hcount<1280, every covering sprite's collision bit is set.
- If set and W1C hit the same bit in the same cycle, set wins.

Output:
- pix_hit = delayed cover AND (rom_q != 0).
- pix_color = rom_q when pix_hit, else 0.

## Timing

- Pipeline, for a given hcount/vcount sample at cycle T:
  - Cycle T: cover test and priority select (combinational).
  - T+1: rom_addr registered.
  - T+1+ROM_LATENCY: rom_q valid.
  - T+2+ROM_LATENCY: pix_hit and pix_color registered.
  - Total latency ROM_LATENCY+2 (default 4); the cover flag is delayed by a matching shift register.
- Avalon:
  - Writes take effect at the next clk edge.
  - readdata is registered, 1-cycle latency, and holds until the next read.
- A staging write in the same cycle as the shadow copy: the copy takes the pre-write value; the new value appears at the next frame_start.
- Reset (reset_n=0 at a clk edge) clears all staging/active registers, status, control, pipeline, readdata, rom_addr, pix_hit and pix_color to 0.
  - Reset mid-frame: outputs are 0 from the next cycle; all sprites are disabled until rewritten.

## Test plan

1. Reset then idle, any hcount/vcount: pix_hit=0, pix_color=0, rom_addr=0, all readdata=0.
2. shadow_mode=0; sprite0 = {enable, x=100}, {frame=2, y=50}; rom_q returns 0x07 for nonzero addr.
   - Scan px=100, py=50 (hcount=200, vcount=50): rom_addr = {6'd2,4'd0,4'd0} one cycle later; pix_hit=1 and pix_color=7 four cycles after the sample.
   - px=116: pix_hit=0.
3. hflip=1, vflip=1 on sprite0 at px=101, py=50: rom_addr row=15, col=14.
   - rom_q=0: pix_hit=0 (transparent).
4. Sprites 0 and 2 both at (200,200):
   - Output uses sprite0's frame.
   - Status reads 0b0101.
   - Write 0b0001 to status with no further overlap: status reads 0b0100.
5. shadow_mode=1: move sprite1 x from 10 to 300 at vcount=100.
   - Rendering stays at x=10 until the copy the cycle after (hcount=0, vcount=480); from the next frame it renders at x=300.
   - A write in the same cycle as that copy is deferred one frame.
6. ROM_LATENCY=1 and 4 builds: pix outputs arrive 3 and 6 cycles after the sample.
   - reset_n low mid-line: pix_hit=0 the following cycle.
